// File: rtl/bldc_startup_sequencer_if.sv
// ----------------------------------------------------------------------------
// bldc_startup_sequencer_if
// Control/status bundle between the motor-enable logic (master) and the BLDC
// start-up sequencer (slave).
//   enable                    master -> slave  start-up / run request (level)
//   fault                     master -> slave  overcurrent / driver fault (level)
//   align_duty                slave -> master  alignment vector duty
//   apply_initial_commutation slave -> master  drive the alignment vector
//   reset_encoder_count       slave -> master  hold encoder counter at zero
//   run                       slave -> master  normal commutation permitted
//   fault_latched             slave -> master  sequencer is in FAULT
//   retry_count               slave -> master  automatic retries consumed
// ----------------------------------------------------------------------------
interface bldc_startup_sequencer_if #(
    parameter int unsigned DUTY_W = 8
);
    logic              enable;
    logic              fault;
    logic [DUTY_W-1:0] align_duty;
    logic              apply_initial_commutation;
    logic              reset_encoder_count;
    logic              run;
    logic              fault_latched;
    logic [1:0]        retry_count;

    modport master (
        output enable, fault,
        input  align_duty, apply_initial_commutation, reset_encoder_count,
               run, fault_latched, retry_count
    );

    modport slave (
        input  enable, fault,
        output align_duty, apply_initial_commutation, reset_encoder_count,
               run, fault_latched, retry_count
    );
endinterface

// File: rtl/bldc_startup_sequencer.sv
// ----------------------------------------------------------------------------
// bldc_startup_sequencer
// BLDC start-up sequencer: on enable it ramps the alignment duty, holds the
// alignment vector, zeroes the encoder and then permits normal commutation,
// supervising the fault input throughout.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous, active-high reset
//   sif    slave modport of bldc_startup_sequencer_if (enable/fault in,
//          align_duty/apply_initial_commutation/reset_encoder_count/run/
//          fault_latched/retry_count out, all registered)
// Build option:
//   BLDC_SEQ_AUTO_RETRY_EN  when defined, FAULT backs off RETRY_TICKS cycles
//                           and retries up to RETRY_MAX times; otherwise
//                           FAULT is sticky until enable drops.
// ----------------------------------------------------------------------------
module bldc_startup_sequencer #(
    parameter int unsigned CNT_W           = 32,
    parameter int unsigned DUTY_W          = 8,
    parameter int unsigned ALIGN_DUTY_MAX  = 128,
    parameter int unsigned RAMP_STEP_TICKS = 1000,
    parameter int unsigned ALIGN_TICKS     = 100000000,
    parameter int unsigned ZERO_TICKS      = 5000000,
    parameter int unsigned RETRY_TICKS     = 50000000,
    parameter int unsigned RETRY_MAX       = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    bldc_startup_sequencer_if.slave   sif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN_RAMP,
        S_ALIGN_HOLD,
        S_ZERO_ENC,
        S_RUN,
        S_FAULT
    } state_t;

    // Counter loads are N-1: a state exits on the edge where the counter is 0
    localparam logic [CNT_W-1:0]  RAMP_LOAD  = CNT_W'(RAMP_STEP_TICKS - 1);
    localparam logic [CNT_W-1:0]  ALIGN_LOAD = CNT_W'(ALIGN_TICKS - 1);
    localparam logic [CNT_W-1:0]  ZERO_LOAD  = CNT_W'(ZERO_TICKS - 1);
`ifdef BLDC_SEQ_AUTO_RETRY_EN
    localparam logic [CNT_W-1:0]  FAULT_LOAD = CNT_W'(RETRY_TICKS - 1);
`else
    localparam logic [CNT_W-1:0]  FAULT_LOAD = '0;
`endif
    localparam logic [DUTY_W-1:0] DUTY_MAX   = DUTY_W'(ALIGN_DUTY_MAX);

    // Elaboration-time parameter sanity
    if (ALIGN_DUTY_MAX < 1 || ALIGN_DUTY_MAX >= (2 ** DUTY_W) ||
        RAMP_STEP_TICKS < 1 || ALIGN_TICKS < 1 || ZERO_TICKS < 1 ||
        RETRY_TICKS < 1) begin : g_bad_param
        $error("bldc_startup_sequencer: illegal parameter value");
    end
    if (RETRY_MAX > 3) begin : g_retry_cap
        $warning("bldc_startup_sequencer: retries are capped at 3 by retry_count");
    end

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_dec;
    logic [DUTY_W-1:0] r_duty, w_duty_nxt, w_duty_inc;
    logic [1:0]        r_retry, w_retry_nxt;
    logic              r_apply, w_apply_nxt;
    logic              r_zero, w_zero_nxt;
    logic              r_run, w_run_nxt;
    logic              r_fault, w_fault_nxt;
    logic              w_cnt_zero;

    assign w_cnt_zero = (r_cnt == '0);
    assign w_cnt_dec  = r_cnt - CNT_W'(1);
    assign w_duty_inc = r_duty + DUTY_W'(1);

    // Next-state, counter, duty and registered-output decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_zero ? r_cnt : w_cnt_dec;   // saturates at 0
        w_duty_nxt  = r_duty;
        w_retry_nxt = r_retry;

        if (!sif.enable) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_retry_nxt = '0;
        end else if (sif.fault && (r_state != S_IDLE)) begin
            // Already in FAULT: back-off timer keeps running, no reload
            if (r_state != S_FAULT) begin
                w_state_nxt = S_FAULT;
                w_cnt_nxt   = FAULT_LOAD;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_ALIGN_RAMP;
                    w_cnt_nxt   = RAMP_LOAD;
                    w_duty_nxt  = '0;
                end
                S_ALIGN_RAMP: begin
                    if (w_cnt_zero) begin
                        w_duty_nxt = w_duty_inc;
                        if (w_duty_inc == DUTY_MAX) begin
                            w_state_nxt = S_ALIGN_HOLD;
                            w_cnt_nxt   = ALIGN_LOAD;
                        end else begin
                            w_cnt_nxt   = RAMP_LOAD;
                        end
                    end
                end
                S_ALIGN_HOLD: begin
                    if (w_cnt_zero) begin
                        w_state_nxt = S_ZERO_ENC;
                        w_cnt_nxt   = ZERO_LOAD;
                    end
                end
                S_ZERO_ENC: begin
                    if (w_cnt_zero) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                end
                S_FAULT: begin
`ifdef BLDC_SEQ_AUTO_RETRY_EN
                    if (w_cnt_zero && (32'(r_retry) < RETRY_MAX) && (r_retry != 2'd3)) begin
                        w_state_nxt = S_ALIGN_RAMP;
                        w_cnt_nxt   = RAMP_LOAD;
                        w_duty_nxt  = '0;
                        w_retry_nxt = r_retry + 2'd1;
                    end
`endif
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

`ifndef BLDC_SEQ_AUTO_RETRY_EN
        w_retry_nxt = '0;
`endif

        // Outputs follow the next state so they change on the same edge
        w_apply_nxt = (w_state_nxt == S_ALIGN_RAMP) || (w_state_nxt == S_ALIGN_HOLD);
        w_zero_nxt  = (w_state_nxt == S_ZERO_ENC);
        w_run_nxt   = (w_state_nxt == S_RUN);
        w_fault_nxt = (w_state_nxt == S_FAULT);
        if (!w_apply_nxt) begin
            w_duty_nxt = '0;
        end
    end

    // State, counter and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_duty  <= '0;
            r_retry <= '0;
            r_apply <= 1'b0;
            r_zero  <= 1'b0;
            r_run   <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_duty  <= w_duty_nxt;
            r_retry <= w_retry_nxt;
            r_apply <= w_apply_nxt;
            r_zero  <= w_zero_nxt;
            r_run   <= w_run_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    assign sif.align_duty                = r_duty;
    assign sif.apply_initial_commutation = r_apply;
    assign sif.reset_encoder_count       = r_zero;
    assign sif.run                       = r_run;
    assign sif.fault_latched             = r_fault;
    assign sif.retry_count               = r_retry;

endmodule

// File: tb/tb_bldc_startup_sequencer.sv
// ----------------------------------------------------------------------------
// tb_bldc_startup_sequencer
// Directed bench for bldc_startup_sequencer with ALIGN_DUTY_MAX=4,
// RAMP_STEP_TICKS=3, ALIGN_TICKS=10, ZERO_TICKS=5, RETRY_TICKS=8, RETRY_MAX=2.
// Each table record drives enable/fault for a number of cycles and gives the
// outputs expected after every one of those edges. Retry expectations follow
// BLDC_SEQ_AUTO_RETRY_EN.
// ----------------------------------------------------------------------------
module tb_bldc_startup_sequencer;

    localparam int unsigned DUTY_W = 8;

    typedef struct {
        logic              en;
        logic              flt;
        int unsigned       reps;
        logic [DUTY_W-1:0] duty;
        logic              apply;
        logic              zero;
        logic              run;
        logic              latched;
        logic [1:0]        retry;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[$];

    bldc_startup_sequencer_if #(.DUTY_W(DUTY_W)) sif ();

    bldc_startup_sequencer #(
        .CNT_W           (32),
        .DUTY_W          (DUTY_W),
        .ALIGN_DUTY_MAX  (4),
        .RAMP_STEP_TICKS (3),
        .ALIGN_TICKS     (10),
        .ZERO_TICKS      (5),
        .RETRY_TICKS     (8),
        .RETRY_MAX       (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sif   (sif)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic en, input logic flt, input int unsigned reps,
                                input int unsigned duty, input logic apply, input logic zero,
                                input logic run, input logic latched, input int unsigned retry);
        vec_t v;
        v.en = en; v.flt = flt; v.reps = reps;
        v.duty = DUTY_W'(duty); v.apply = apply; v.zero = zero;
        v.run = run; v.latched = latched; v.retry = 2'(retry);
        return v;
    endfunction

    task automatic add(input logic en, input logic flt, input int unsigned reps,
                       input int unsigned duty, input logic apply, input logic zero,
                       input logic run, input logic latched, input int unsigned retry);
        vecs.push_back(mk(en, flt, reps, duty, apply, zero, run, latched, retry));
    endtask

    // 4 duty steps x 3 cycles, 10 hold cycles at duty 4, 5 encoder-zero cycles
    task automatic add_to_zero(input int unsigned rc);
        for (int d = 0; d < 4; d++) add(1, 0, 3, d, 1, 0, 0, 0, rc);
        add(1, 0, 10, 4, 1, 0, 0, 0, rc);
        add(1, 0, 5, 0, 0, 1, 0, 0, rc);
    endtask

    task automatic check(input string name, input vec_t e);
        logic [DUTY_W+5:0] act, exp;
        act = {sif.align_duty, sif.apply_initial_commutation, sif.reset_encoder_count,
               sif.run, sif.fault_latched, sif.retry_count};
        exp = {e.duty, e.apply, e.zero, e.run, e.latched, e.retry};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: duty/apply/zero/run/latched/retry got %0d/%b/%b/%b/%b/%0d want %0d/%b/%b/%b/%b/%0d",
                     name, sif.align_duty, sif.apply_initial_commutation, sif.reset_encoder_count,
                     sif.run, sif.fault_latched, sif.retry_count,
                     e.duty, e.apply, e.zero, e.run, e.latched, e.retry);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        bit  got;
        vec_t idle0;

        idle0 = mk(0, 0, 1, 0, 0, 0, 0, 0, 0);
        sif.enable = 1'b0;
        sif.fault  = 1'b0;

        // ---- stimulus table ----
        // Nominal start then a fault pulse in RUN
        add_to_zero(0);
        add(1, 0, 4, 0, 0, 0, 1, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0, 1, 0);
`ifdef BLDC_SEQ_AUTO_RETRY_EN
        add(1, 0, 7, 0, 0, 0, 0, 1, 0);
        add_to_zero(1);
        add(1, 0, 3, 0, 0, 0, 1, 0, 1);
        add(1, 1, 1, 0, 0, 0, 0, 1, 1);
        add(1, 0, 7, 0, 0, 0, 0, 1, 1);
        add_to_zero(2);
        add(1, 0, 3, 0, 0, 0, 1, 0, 2);
        add(1, 1, 1, 0, 0, 0, 0, 1, 2);
        add(1, 0, 20, 0, 0, 0, 0, 1, 2);
`else
        add(1, 0, 20, 0, 0, 0, 0, 1, 0);
`endif
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);
        // Fault while idle is ignored
        add(0, 1, 2, 0, 0, 0, 0, 0, 0);
        // Enable dropped mid-ramp at duty 2, then restart from duty 0
        add(1, 0, 3, 0, 1, 0, 0, 0, 0);
        add(1, 0, 3, 1, 1, 0, 0, 0, 0);
        add(1, 0, 1, 2, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int d = 0; d < 4; d++) add(1, 0, 3, d, 1, 0, 0, 0, 0);
        // Fault pulse during ALIGN_HOLD
        add(1, 0, 2, 4, 1, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0, 1, 0);
        add(1, 0, 5, 0, 0, 0, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);
        // Fault on the last ZERO_ENC cycle: FAULT wins, run never asserts
        add_to_zero(0);
        add(1, 1, 1, 0, 0, 0, 0, 1, 0);
        add(1, 0, 4, 0, 0, 0, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);

        // ---- reset ----
        #2 reset = 1'b1;
        #1 check("reset_async", idle0);
        repeat (2) @(posedge clk);
        #1 check("reset_held", idle0);
        reset = 1'b0;
        @(posedge clk);
        #1 check("idle_after_reset", idle0);

        // ---- enable-to-run latency, bounded wait ----
        sif.enable = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (cyc < 60 && !got) begin
            @(posedge clk);
            #1;
            cyc++;
            if (sif.run) got = 1'b1;
        end
        n_vec++;
        if (!got || cyc != 28) begin
            n_err++;
            $display("FAIL run_latency: got %0d cycles (seen=%0b) want 28", cyc, got);
        end
        sif.enable = 1'b0;
        @(posedge clk);
        #1 check("latency_idle", idle0);

        // ---- table ----
        for (int i = 0; i < int'(vecs.size()); i++) begin
            for (int k = 0; k < int'(vecs[i].reps); k++) begin
                sif.enable = vecs[i].en;
                sif.fault  = vecs[i].flt;
                @(posedge clk);
                #1 check($sformatf("vec%0d.%0d", i, k), vecs[i]);
            end
        end
        sif.fault = 1'b0;

        // ---- async reset during ZERO_ENC ----
        sif.enable = 1'b1;
        repeat (24) @(posedge clk);
        #1 check("pre_reset_zero_enc", mk(1, 0, 1, 0, 0, 1, 0, 0, 0));
        #2 reset = 1'b1;
        #1 check("mid_cycle_reset", idle0);
        sif.enable = 1'b0;
        @(posedge clk);
        #1 check("reset_held_zero_enc", idle0);
        reset = 1'b0;
        @(posedge clk);
        #1 check("idle_after_mid_reset", idle0);
        sif.enable = 1'b1;
        @(posedge clk);
        #1 check("restart_after_reset", mk(1, 0, 1, 0, 1, 0, 0, 0, 0));
        sif.enable = 1'b0;
        @(posedge clk);
        #1 check("final_idle", idle0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bldc_startup_sequencer.md
# bldc_startup_sequencer

Parametrised BLDC start-up sequencer that replaces the fixed two-delay power-up FSM. On `enable` it ramps the alignment vector duty, holds alignment, zeroes the encoder, then hands off to normal commutation. It supervises a `fault` input throughout. It sits between the top-level motor enable and the commutation/PWM and encoder blocks of the velocity controller.

## Interface
Parameters:
- CNT_W, 32, width of the delay counter
- DUTY_W, 8, width of `align_duty`
- ALIGN_DUTY_MAX, 128, final alignment duty (≥1, < 2^DUTY_W)
- RAMP_STEP_TICKS, 1000, cycles per duty increment (≥1)
- ALIGN_TICKS, 100000000, alignment hold cycles (≥1)
- ZERO_TICKS, 5000000, encoder-zero cycles (≥1)
- RETRY_TICKS, 50000000, fault back-off cycles (≥1; auto-retry only)
- RETRY_MAX, 3, maximum automatic retries (auto-retry only)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- enable  in  1  level; high requests start-up and run
- fault  in  1  level; overcurrent or driver fault, sampled every cycle
- align_duty  out  DUTY_W  duty for the alignment vector
- apply_initial_commutation  out  1  drive the alignment vector
- reset_encoder_count  out  1  hold encoder counter at zero
- run  out  1  normal commutation permitted
- fault_latched  out  1  sequencer is in FAULT
- retry_count  out  2  retries consumed, saturating at 3

## Operation
- States: IDLE, ALIGN_RAMP, ALIGN_HOLD, ZERO_ENC, RUN, FAULT.
- Transitions, evaluated in priority order each edge:
  1. `enable`=0 → IDLE from any state. This also clears `retry_count`.
  2. `fault`=1 in any state except IDLE → FAULT.
  3. Otherwise the normal sequence below.
- IDLE → ALIGN_RAMP when `enable`=1.
- ALIGN_RAMP:
  - `align_duty` starts at 0 on entry and increments by 1 every RAMP_STEP_TICKS cycles.
  - The increment that reaches ALIGN_DUTY_MAX moves to ALIGN_HOLD.
- ALIGN_HOLD: lasts ALIGN_TICKS cycles at duty ALIGN_DUTY_MAX, then → ZERO_ENC.
- ZERO_ENC: lasts ZERO_TICKS cycles, then → RUN.
- RUN: terminal while `enable`=1 and `fault`=0.
- Single down-counter:
  - Loaded with N−1 on state entry. The state exits on the edge where the counter is 0, so each state lasts exactly N cycles.
  - The counter never wraps.
- Output decode:
  - `apply_initial_commutation`=1 in ALIGN_RAMP and ALIGN_HOLD.
  - `reset_encoder_count`=1 in ZERO_ENC.
  - `run`=1 in RUN.
  - `fault_latched`=1 in FAULT.
  - `align_duty` is 0 outside ALIGN_RAMP and ALIGN_HOLD.
- Reset: state IDLE, counter 0. All outputs are 0, including `align_duty` and `retry_count`.

## Timing
- All outputs are registered and update on the same edge as the state register. An output asserts in the first cycle of its state and deasserts in the first cycle of the next state.
- Alignment ramp lasts ALIGN_DUTY_MAX×RAMP_STEP_TICKS cycles.
- Total `enable`-to-`run` latency is 1 + ALIGN_DUTY_MAX×RAMP_STEP_TICKS + ALIGN_TICKS + ZERO_TICKS cycles.
- `fault` or `enable` deassertion takes effect on the next edge (1-cycle response). All drive outputs are 0 in the following cycle.
- If `fault` and counter expiry occur on the same edge, the result is FAULT.
- `fault` in IDLE is ignored.
- Asynchronous reset mid-sequence forces IDLE immediately. A new sequence starts from ALIGN_RAMP with duty 0.

## Configuration
- `BLDC_SEQ_AUTO_RETRY_EN` defined:
  - FAULT loads RETRY_TICKS. On expiry, if `fault`=0 and `retry_count` < RETRY_MAX, the block increments `retry_count` and goes to ALIGN_RAMP.
  - Otherwise it remains in FAULT until `enable`=0.
  - Reaching RUN does not clear `retry_count`.
- Not defined:
  - FAULT is sticky until `enable`=0.
  - `retry_count` is tied to 0 and the RETRY_* parameters are unused.

## Test plan
All scenarios use ALIGN_DUTY_MAX=4, RAMP_STEP_TICKS=3, ALIGN_TICKS=10, ZERO_TICKS=5, RETRY_TICKS=8, RETRY_MAX=2.
- Nominal start: `enable`↑ → `align_duty` steps 0,1,2,3,4 every 3 cycles. `apply_initial_commutation` is high for 22 cycles, `reset_encoder_count` is high for 5 cycles, and `run` asserts 28 cycles after `enable`↑.
- Fault in ALIGN_HOLD: 1-cycle `fault` pulse → next cycle `fault_latched`=1 with all drive outputs and `align_duty` at 0.
  - Without the macro: stays latched until `enable`=0, then IDLE.
- Auto-retry (macro defined): fault pulses in RUN → after 8 cycles, re-enters ALIGN_RAMP with `retry_count`=1, then 2. A third fault remains in FAULT.
- Simultaneous events: `fault` on the last ZERO_ENC cycle → FAULT, and `run` never asserts.
- `enable` dropped mid-ramp at duty 2 → next cycle IDLE with all outputs 0. Re-enable restarts the ramp at duty 0.
- Async `reset` pulse during ZERO_ENC → all outputs 0 immediately. Returns to IDLE with `retry_count`=0.
